// File: rtl/mux16_arb_pkg.sv
// -----------------------------------------------------------------------------
// mux16_arb_pkg
// Shared types and constants for the 16-way round-robin arbiter that drives
// the select of the shared MUX16to1 bit-select datapath.
//   arb_state_e : arbiter FSM states (IDLE, GRANT)
//   N_REQ       : number of requesters (16)
//   SEL_W       : width of the requester index / mux select (4)
// -----------------------------------------------------------------------------
package mux16_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // One-hot decode of a requester index.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        idx_to_onehot = 16'd1 << idx;
    endfunction

endpackage

// File: rtl/MUX16to1.sv
// -----------------------------------------------------------------------------
// MUX16to1
// Plain 16-to-1 single-bit multiplexer (shared bit-select datapath).
// Ports:
//   d [15:0] : data inputs
//   s [3:0]  : select
//   y        : d[s]
// -----------------------------------------------------------------------------
module MUX16to1 (
    input  logic [15:0] d,
    input  logic [3:0]  s,
    output logic        y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick16.sv
// -----------------------------------------------------------------------------
// rr_pick16
// Combinational rotating-priority picker. Returns the first set request found
// when searching base, base+1, ... modulo 16.
// Ports:
//   req  [15:0] : request vector
//   base [3:0]  : highest-priority index for this search
//   idx  [3:0]  : winning index (don't-care when any==0)
//   any         : at least one request is set
// -----------------------------------------------------------------------------
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] base,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] cand_s;

    // Scan from the furthest offset back toward base so the closest set
    // request (smallest offset from base) is the last one written.
    always_comb begin
        idx    = base;
        cand_s = base;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = base + SEL_W'(i);
            idx    = req[cand_s] ? cand_s : idx;
        end
    end

    assign any = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux16_rr_arbiter
// Round-robin arbiter/sequencer for the shared MUX16to1 datapath. Grants one
// of 16 requesters for a burst of BURST_LEN cycles, drives the registered
// mux select, and forwards the selected data bit with a valid qualifier.
// Optional feature macro: MUX16_ARB_LOCK_EN (adds the lock input that lets
// the current owner extend its grant by further full bursts).
// Parameters:
//   BURST_LEN : cycles per grant (1..255)
//   CNT_W     : burst counter width, must hold BURST_LEN-1
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   req[15:0] : request lines
//   din[15:0] : per-requester serial data
//   lock      : (MUX16_ARB_LOCK_EN only) extend the current grant
//   gnt[15:0] : registered one-hot grant
//   sel[3:0]  : registered mux select
//   valid     : grant active
//   dout      : din[sel] qualified by valid
//   done      : high on the final cycle of a grant
// -----------------------------------------------------------------------------
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] din,
`ifdef MUX16_ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             valid,
    output logic             dout,
    output logic             done
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST_LEN - 1);

    arb_state_e       state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [N_REQ-1:0] gnt_q,   gnt_d;
    logic             valid_q, valid_d;

    logic             lock_s;
    logic             in_grant_s;
    logic             cnt_zero_s;
    logic             release_s;
    logic             extend_s;
    logic             final_s;
    logic [SEL_W-1:0] pick_base_s;
    logic [SEL_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic             mux_y_s;

`ifdef MUX16_ARB_LOCK_EN
    assign lock_s = lock;
`else
    assign lock_s = 1'b0;
`endif

    assign in_grant_s = (state_q == ST_GRANT);
    assign cnt_zero_s = (cnt_q == {CNT_W{1'b0}});
    assign release_s  = ~req[sel_q];
    // Lock only stretches a burst that ran to completion; an early release
    // always ends the grant.
    assign extend_s   = in_grant_s & cnt_zero_s & ~release_s & lock_s;
    assign final_s    = in_grant_s & (cnt_zero_s | release_s) & ~extend_s;

    // On a final cycle the next winner is searched from sel+1, i.e. the
    // pointer value being written this cycle, so hand-over has no bubble.
    assign pick_base_s = in_grant_s ? (sel_q + 4'd1) : ptr_q;

    rr_pick16 u_pick (
        .req  (req),
        .base (pick_base_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    MUX16to1 u_mux (
        .d (din),
        .s (sel_q),
        .y (mux_y_s)
    );

    // Next-state, pointer, counter and grant computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx_s;
                    gnt_d   = idx_to_onehot(pick_idx_s);
                    cnt_d   = CNT_LOAD;
                    valid_d = 1'b1;
                end else begin
                    gnt_d   = {N_REQ{1'b0}};
                    valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (extend_s) begin
                    cnt_d = CNT_LOAD;
                end else if (final_s) begin
                    ptr_d = sel_q + 4'd1;
                    if (pick_any_s) begin
                        sel_d   = pick_idx_s;
                        gnt_d   = idx_to_onehot(pick_idx_s);
                        cnt_d   = CNT_LOAD;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = {N_REQ{1'b0}};
                        valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = {N_REQ{1'b0}};
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {SEL_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            sel_q   <= {SEL_W{1'b0}};
            gnt_q   <= {N_REQ{1'b0}};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign dout  = mux_y_s & valid_q;
    // A reset cycle aborts the grant, so it never reports completion.
    assign done  = final_s & ~rst;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux16_rr_arbiter
// Self-checking bench for mux16_rr_arbiter. A cycle model predicts the
// outputs for each cycle when the stimulus is applied; the prediction is
// queued and then compared with what the DUT shows a moment later.
// -----------------------------------------------------------------------------
module tb_mux16_rr_arbiter;

    localparam int BL = 4;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] din;
`ifdef MUX16_ARB_LOCK_EN
    logic        lock;
`endif
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    logic        dout;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    // expected {gnt, sel, valid, dout, done}
    logic [22:0] exp_q[$];

    // reference model state
    int m_state = 0;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_sel   = 0;

    mux16_rr_arbiter #(.BURST_LEN(BL), .CNT_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
`ifdef MUX16_ARB_LOCK_EN
        .lock  (lock),
`endif
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .dout  (dout),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic lock_now();
`ifdef MUX16_ARB_LOCK_EN
        return lock;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int pick(int base);
        for (int i = 0; i < 16; i++) begin
            if (req[(base + i) % 16]) return (base + i) % 16;
        end
        return -1;
    endfunction

    function automatic logic m_extend();
        return (m_state == 1) && (m_cnt == 0) && req[m_sel] && lock_now();
    endfunction

    function automatic logic m_final();
        return (m_state == 1) && ((m_cnt == 0) || !req[m_sel]) && !m_extend();
    endfunction

    function automatic logic [22:0] model_out();
        logic [15:0] g;
        logic        v;
        logic        d;
        g = (m_state == 1) ? (16'h0001 << m_sel) : 16'h0000;
        v = (m_state == 1);
        d = (m_state == 1) ? din[m_sel] : 1'b0;
        return {g, 4'(m_sel), v, d, m_final() && !rst};
    endfunction

    task automatic model_edge();
        int p;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_cnt = 0; m_sel = 0;
        end else if (m_state == 0) begin
            p = pick(m_ptr);
            if (p >= 0) begin m_state = 1; m_sel = p; m_cnt = BL - 1; end
        end else if (m_extend()) begin
            m_cnt = BL - 1;
        end else if (m_final()) begin
            m_ptr = (m_sel + 1) % 16;
            p = pick(m_ptr);
            if (p >= 0) begin m_sel = p; m_cnt = BL - 1; end
            else m_state = 0;
        end else begin
            m_cnt = m_cnt - 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 16'h0000;
`ifdef MUX16_ARB_LOCK_EN
        lock = 1'b0;
`endif
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] e, o;
        do_reset();
        din = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL reset_sb c%0d: got %h want %h", c, o, e); end
            n_tests++;
            if ({gnt, valid, dout, done} !== 19'h0) begin
                n_fail++; $display("FAIL reset_idle c%0d: got gnt=%h v=%b d=%b done=%b want all 0", c, gnt, valid, dout, done);
            end
            cyc();
        end
    endtask

    task automatic test_single_burst();
        logic [22:0] e, o;
        int first_v, first_d;
        first_v = -1; first_d = -1;
        do_reset();
        din = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            req = 16'h0001;
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL single_sb c%0d: got %h want %h", c, o, e); end
            if (valid === 1'b1 && first_v < 0) first_v = c;
            if (done === 1'b1 && first_d < 0) first_d = c;
            if (valid === 1'b1) begin
                n_tests++;
                if (gnt !== 16'h0001 || sel !== 4'd0) begin
                    n_fail++; $display("FAIL single_gnt c%0d: got gnt=%h sel=%0d want 0001/0", c, gnt, sel);
                end
            end
            cyc();
        end
        n_tests++;
        if (first_v !== 1 || first_d !== 4) begin
            n_fail++; $display("FAIL single_len: got valid@%0d done@%0d want 1/4", first_v, first_d);
        end
    endtask

    task automatic test_alternate();
        logic [22:0] e, o;
        int exp_sel;
        exp_sel = 0;
        do_reset();
        din = 16'h8001;
        for (int c = 0; c < 22; c++) begin
            req = 16'h8001;
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL alt_sb c%0d: got %h want %h", c, o, e); end
            if (c >= 1) begin
                n_tests++;
                if (valid !== 1'b1 || sel !== 4'(exp_sel) || dout !== 1'b1) begin
                    n_fail++; $display("FAIL alt_seq c%0d: got v=%b sel=%0d d=%b want 1/%0d/1", c, valid, sel, dout, exp_sel);
                end
                if (done === 1'b1) exp_sel = (exp_sel == 0) ? 15 : 0;
            end
            cyc();
        end
    endtask

    task automatic test_dout();
        logic [22:0] e, o;
        do_reset();
        din = 16'hA5A5;
        for (int c = 0; c < 9; c++) begin
            req = (c < 5) ? 16'h0020 : 16'h0000;
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL dout_sb c%0d: got %h want %h", c, o, e); end
            n_tests++;
            if (dout !== valid) begin
                n_fail++; $display("FAIL dout_a5 c%0d: got dout=%b want %b", c, dout, valid);
            end
            cyc();
        end
    endtask

    task automatic test_early_release();
        logic [22:0] e, o;
        logic [15:0] pat[8];
        pat = '{16'h0008, 16'h040A, 16'h0402, 16'h0402, 16'h0402, 16'h0402, 16'h0402, 16'h0000};
        do_reset();
        din = 16'h0408;
        for (int c = 0; c < 8; c++) begin
            req = pat[c];
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL early_sb c%0d: got %h want %h", c, o, e); end
            if (c == 2) begin
                n_tests++;
                if (done !== 1'b1 || sel !== 4'd3) begin
                    n_fail++; $display("FAIL early_done: got done=%b sel=%0d want 1/3", done, sel);
                end
            end
            if (c == 3) begin
                n_tests++;
                if (gnt !== 16'h0400 || sel !== 4'd10 || done !== 1'b0) begin
                    n_fail++; $display("FAIL early_next: got gnt=%h sel=%0d done=%b want 0400/10/0", gnt, sel, done);
                end
            end
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] e, o;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ((c % 3) == 0) req = 16'($urandom) & 16'($urandom);
            din = 16'($urandom);
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rand_sb c%0d: got %h want %h", c, o, e); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        logic [22:0] e, o;
        do_reset();
        din = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            req = 16'h0200;
            rst = (c == 3);
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL rstmid_sb c%0d: got %h want %h", c, o, e); end
            if (c == 4) begin
                n_tests++;
                if ({gnt, sel, valid, dout, done} !== 23'h0) begin
                    n_fail++; $display("FAIL rstmid_clear: got gnt=%h sel=%0d v=%b d=%b done=%b want all 0", gnt, sel, valid, dout, done);
                end
            end
            cyc();
        end
        rst = 1'b0;
    endtask

`ifdef MUX16_ARB_LOCK_EN
    task automatic test_lock();
        logic [22:0] e, o;
        do_reset();
        din = 16'h0080;
        for (int c = 0; c < 3 * BL + 4; c++) begin
            req  = 16'h0180;
            lock = (c < 3 * BL);
            exp_q.push_back(model_out());
            #1;
            o = {gnt, sel, valid, dout, done};
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL lock_sb c%0d: got %h want %h", c, o, e); end
            if (c >= 1 && c < 3 * BL) begin
                n_tests++;
                if (gnt !== 16'h0080 || done !== 1'b0) begin
                    n_fail++; $display("FAIL lock_hold c%0d: got gnt=%h done=%b want 0080/0", c, gnt, done);
                end
            end
            if (c == 3 * BL) begin
                n_tests++;
                if (gnt !== 16'h0080 || done !== 1'b1) begin
                    n_fail++; $display("FAIL lock_end: got gnt=%h done=%b want 0080/1", gnt, done);
                end
            end
            if (c == 3 * BL + 1) begin
                n_tests++;
                if (sel !== 4'd8) begin
                    n_fail++; $display("FAIL lock_ptr: got sel=%0d want 8", sel);
                end
            end
            cyc();
        end
        lock = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 16'h0000;
        din = 16'h0000;
`ifdef MUX16_ARB_LOCK_EN
        lock = 1'b0;
`endif
        test_reset();
        test_single_burst();
        test_alternate();
        test_dout();
        test_early_release();
        test_back_to_back();
        test_reset_mid();
`ifdef MUX16_ARB_LOCK_EN
        test_lock();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
